// File: rtl/czonotope_loader_if.sv
// Register-level view of one constrained zonotope in CG-rep (c, G, A, b).
// The loader drives it through `out`; downstream stages read it through `in`.
interface CZonotope #(
  parameter int DATA_WIDTH = 32,
  parameter int NMAX       = 3,
  parameter int NGMAX      = 15,
  parameter int NCMAX      = 12
);
  logic [DATA_WIDTH-1:0] n;
  logic [DATA_WIDTH-1:0] ng;
  logic [DATA_WIDTH-1:0] nc;
  logic [DATA_WIDTH-1:0] c [NMAX];
  logic [DATA_WIDTH-1:0] g [NMAX][NGMAX];
  logic [DATA_WIDTH-1:0] a [NCMAX][NGMAX];
  logic [DATA_WIDTH-1:0] b [NCMAX];

  modport out (output n, ng, nc, c, g, a, b);
  modport in  (input  n, ng, nc, c, g, a, b);
endinterface

// File: rtl/czonotope_loader.sv
// Stream-to-register loader: parses a header (n, ng, nc) and the c, G, A, b
// sections from a valid/ready word stream and holds the set until acked.
module czonotope_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int NMAX       = 3,
  parameter int NGMAX      = 15,
  parameter int NCMAX      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  CZonotope.out                 czo,
  output logic                  cz_valid,
  input  logic                  cz_ack,
  output logic                  err
);

  localparam int RMAX = (NMAX > NCMAX) ? NMAX : NCMAX;
  localparam int IW   = $clog2(RMAX + 1);
  localparam int CW   = $clog2(NGMAX + 1);

  typedef enum logic [3:0] {
    H_N, H_NG, H_NC, LD_C, LD_G, LD_A, LD_B, HOLD, ERR
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   row;
  logic [CW-1:0]   col;
  logic            xfer;
  logic            sect_last;
  logic            n_ok;
  logic            ng_ok;
  logic            nc_ok;
  logic            idx_last_n;
  logic            idx_last_nc;
  logic            row_last_n;
  logic            row_last_nc;
  logic            col_last;
  logic            clear;

  // Gating with rst keeps s_ready low while reset is held; it never sees s_valid.
  assign s_ready  = !rst && (state inside {H_N, H_NG, H_NC, LD_C, LD_G, LD_A, LD_B});
  assign cz_valid = (state == HOLD);
  assign err      = (state == ERR);
  assign xfer     = s_valid && s_ready;

  // Header range checks on the full word, so out-of-range upper bits are caught.
  assign n_ok  = (s_data != '0) && (s_data <= DATA_WIDTH'(NMAX));
  assign ng_ok = (s_data <= DATA_WIDTH'(NGMAX));
  assign nc_ok = (s_data <= DATA_WIDTH'(NCMAX));

  assign idx_last_n  = (DATA_WIDTH'(idx) + DATA_WIDTH'(1)) == czo.n;
  assign idx_last_nc = (DATA_WIDTH'(idx) + DATA_WIDTH'(1)) == czo.nc;
  assign row_last_n  = (DATA_WIDTH'(row) + DATA_WIDTH'(1)) == czo.n;
  assign row_last_nc = (DATA_WIDTH'(row) + DATA_WIDTH'(1)) == czo.nc;
  assign col_last    = (DATA_WIDTH'(col) + DATA_WIDTH'(1)) == czo.ng;

  always_ff @(posedge clk) begin
    if (rst) state <= H_N;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_next = state;
    sect_last  = 1'b0;
    case (state)
      H_N:  if (xfer) state_next = n_ok  ? H_NG : ERR;
      H_NG: if (xfer) state_next = ng_ok ? H_NC : ERR;
      H_NC: if (xfer) state_next = nc_ok ? LD_C : ERR;
      LD_C: if (xfer && idx_last_n) begin
        sect_last = 1'b1;
        if (czo.ng != '0)      state_next = LD_G;
        else if (czo.nc != '0) state_next = LD_B;
        else                   state_next = HOLD;
      end
      LD_G: if (xfer && row_last_n && col_last) begin
        sect_last  = 1'b1;
        state_next = (czo.nc != '0) ? LD_A : HOLD;
      end
      LD_A: if (xfer && row_last_nc && col_last) begin
        sect_last  = 1'b1;
        state_next = LD_B;
      end
      LD_B: if (xfer && idx_last_nc) begin
        sect_last  = 1'b1;
        state_next = HOLD;
      end
      HOLD:    if (cz_ack) state_next = H_N;
      default: state_next = state;
    endcase
  end

  // A new n word wipes the previous set so unused entries read as zero.
  assign clear = rst || (xfer && state == H_N);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      row <= '0;
      col <= '0;
    end else if (xfer) begin
      case (state)
        LD_C, LD_B: idx <= sect_last ? '0 : idx + IW'(1);
        LD_G, LD_A: begin
          if (sect_last) begin
            row <= '0;
            col <= '0;
          end else if (col_last) begin
            row <= row + IW'(1);
            col <= '0;
          end else begin
            col <= col + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      czo.n  <= (!rst && n_ok) ? s_data : '0;
      czo.ng <= '0;
      czo.nc <= '0;
    end else if (xfer && state == H_NG && ng_ok) begin
      czo.ng <= s_data;
    end else if (xfer && state == H_NC && nc_ok) begin
      czo.nc <= s_data;
    end
  end

  // NOTE: the element registers are reset on purpose: reset state is an all-zero set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NMAX; i++) begin
      if (clear)
        czo.c[i] <= '0;
      else if (xfer && state == LD_C && idx == IW'(i))
        czo.c[i] <= s_data;
      for (int j = 0; j < NGMAX; j++) begin
        if (clear)
          czo.g[i][j] <= '0;
        else if (xfer && state == LD_G && row == IW'(i) && col == CW'(j))
          czo.g[i][j] <= s_data;
      end
    end
    for (int i = 0; i < NCMAX; i++) begin
      if (clear)
        czo.b[i] <= '0;
      else if (xfer && state == LD_B && idx == IW'(i))
        czo.b[i] <= s_data;
      for (int j = 0; j < NGMAX; j++) begin
        if (clear)
          czo.a[i][j] <= '0;
        else if (xfer && state == LD_A && row == IW'(i) && col == CW'(j))
          czo.a[i][j] <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_czonotope_loader.sv
// Self-checking bench for czonotope_loader: table of header vectors against a
// stream-parsing reference model, plus hand sequences for reload and reset.
module tb_czonotope_loader;

  // Wider than the default so a 33-bit n header can be presented untruncated.
  localparam int DW    = 40;
  localparam int NMAX  = 3;
  localparam int NGMAX = 15;
  localparam int NCMAX = 12;

  typedef logic [DW-1:0] word_t;

  typedef struct {
    word_t w0;
    word_t w1;
    word_t w2;
    int    mode;      // 0 random data, 1 word k = k, 2 word k = 3k+5
    bit    bubbles;
    bit    exp_err;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  word_t s_data;
  logic  s_valid;
  logic  s_ready;
  logic  cz_valid;
  logic  cz_ack;
  logic  err;

  CZonotope #(.DATA_WIDTH(DW), .NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX)) czo_if ();

  czonotope_loader #(.DATA_WIDTH(DW), .NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .czo      (czo_if),
    .cz_valid (cz_valid),
    .cz_ack   (cz_ack),
    .err      (err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  word_t exp_n, exp_ng, exp_nc;
  word_t exp_c [NMAX];
  word_t exp_g [NMAX][NGMAX];
  word_t exp_a [NCMAX][NGMAX];
  word_t exp_b [NCMAX];

  task automatic check(input string name, input word_t act, input word_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_n = '0; exp_ng = '0; exp_nc = '0;
    for (int i = 0; i < NMAX; i++) begin
      exp_c[i] = '0;
      for (int j = 0; j < NGMAX; j++) exp_g[i][j] = '0;
    end
    for (int i = 0; i < NCMAX; i++) begin
      exp_b[i] = '0;
      for (int j = 0; j < NGMAX; j++) exp_a[i][j] = '0;
    end
  endtask

  // Number of words the loader consumes: up to and including a bad header word.
  function automatic int model_len(input word_t n, input word_t ng, input word_t nc);
    if (n == '0 || n > word_t'(NMAX)) return 1;
    if (ng > word_t'(NGMAX)) return 2;
    if (nc > word_t'(NCMAX)) return 3;
    return 3 + int'(n) + int'(n) * int'(ng) + int'(nc) * int'(ng) + int'(nc);
  endfunction

  // Parse a well-formed word stream into the expected set.
  task automatic model_fill(input word_t w[$]);
    int p, n, ng, nc;
    model_clear();
    exp_n = w[0]; exp_ng = w[1]; exp_nc = w[2];
    n = int'(w[0]); ng = int'(w[1]); nc = int'(w[2]);
    p = 3;
    for (int i = 0; i < n; i++) exp_c[i] = w[p++];
    for (int i = 0; i < n; i++) for (int j = 0; j < ng; j++) exp_g[i][j] = w[p++];
    for (int i = 0; i < nc; i++) for (int j = 0; j < ng; j++) exp_a[i][j] = w[p++];
    for (int i = 0; i < nc; i++) exp_b[i] = w[p++];
  endtask

  task automatic check_set(input string tag);
    check({tag, ".n"},  czo_if.n,  exp_n);
    check({tag, ".ng"}, czo_if.ng, exp_ng);
    check({tag, ".nc"}, czo_if.nc, exp_nc);
    for (int i = 0; i < NMAX; i++) begin
      check($sformatf("%s.c[%0d]", tag, i), czo_if.c[i], exp_c[i]);
      for (int j = 0; j < NGMAX; j++)
        check($sformatf("%s.g[%0d][%0d]", tag, i, j), czo_if.g[i][j], exp_g[i][j]);
    end
    for (int i = 0; i < NCMAX; i++) begin
      check($sformatf("%s.b[%0d]", tag, i), czo_if.b[i], exp_b[i]);
      for (int j = 0; j < NGMAX; j++)
        check($sformatf("%s.a[%0d][%0d]", tag, i, j), czo_if.a[i][j], exp_a[i][j]);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; cz_ack = 1'b0; s_data = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive words at negedges; a word is handed over only when s_ready is high.
  // Returns once the last word's edge has passed (we are at the next negedge).
  task automatic stream(input word_t w[$], input bit bubbles, input bit ack_noise,
                        output int cycles, output bit early);
    int k = 0;
    cycles = 0;
    early  = 1'b0;
    while (k < w.size()) begin
      @(negedge clk);
      if (cycles > 5000) begin
        vectors++; miscompares++;
        $display("FAIL stream_timeout: got %0d of %0d words accepted", k, w.size());
        break;
      end
      if (cz_valid || err) early = 1'b1;
      cz_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bubbles && $urandom_range(0, 1) == 0) begin
        s_valid = 1'b0;
      end else if (s_ready) begin
        s_valid = 1'b1;
        s_data  = w[k];
        k++;
      end else begin
        s_valid = 1'b0;
      end
      cycles++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    cz_ack  = 1'b0;
  endtask

  task automatic build_words(input vec_t v, output word_t w[$]);
    int len;
    len = model_len(v.w0, v.w1, v.w2);
    w = {};
    for (int k = 0; k < len; k++) begin
      if (k == 0)      w.push_back(v.w0);
      else if (k == 1) w.push_back(v.w1);
      else if (k == 2) w.push_back(v.w2);
      else case (v.mode)
        1:       w.push_back(word_t'(k));
        2:       w.push_back(word_t'(k * 3 + 5));
        default: w.push_back(word_t'({$urandom(), $urandom()}));
      endcase
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag, input bit ack_noise);
    word_t w[$];
    int    cyc;
    bit    early;
    build_words(v, w);
    stream(w, v.bubbles, ack_noise, cyc, early);
    check({tag, ".early_flag"}, word_t'(early), '0);
    if (v.exp_err) begin
      check({tag, ".err"},      word_t'(err),      word_t'(1));
      check({tag, ".s_ready"},  word_t'(s_ready),  '0);
      check({tag, ".cz_valid"}, word_t'(cz_valid), '0);
      repeat (3) begin @(negedge clk); s_valid = 1'b1; s_data = word_t'(1); end
      @(negedge clk); s_valid = 1'b0;
      check({tag, ".err_sticky"},     word_t'(err),     word_t'(1));
      check({tag, ".s_ready_sticky"}, word_t'(s_ready), '0);
    end else begin
      model_fill(w);
      check({tag, ".cz_valid"}, word_t'(cz_valid), word_t'(1));
      check({tag, ".s_ready"},  word_t'(s_ready),  '0);
      check({tag, ".err"},      word_t'(err),      '0);
      if (!v.bubbles) check({tag, ".latency"}, word_t'(cyc), word_t'(w.size()));
      check_set(tag);
      repeat (3) begin @(negedge clk); s_valid = 1'b1; s_data = word_t'($urandom()); end
      @(negedge clk); s_valid = 1'b0;
      check({tag, ".hold_valid"}, word_t'(cz_valid), word_t'(1));
      check_set({tag, ".hold"});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    word_t w[$];
    int cyc;
    bit early;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; cz_ack = 1'b0;

    // Reset state while rst is held, then s_ready on the first free cycle.
    @(posedge clk); #1;
    model_clear();
    check("rst.s_ready",  word_t'(s_ready),  '0);
    check("rst.cz_valid", word_t'(cz_valid), '0);
    check("rst.err",      word_t'(err),      '0);
    check_set("rst");
    @(negedge clk); rst = 1'b0; #1;
    check("rst.s_ready_after", word_t'(s_ready), word_t'(1));

    //               n                  ng        nc       mode bub err
    tbl.push_back('{40'd1,              40'd0,    40'd0,   3,   0,  0});
    tbl.push_back('{40'd1,              40'd0,    40'd0,   0,   0,  0});
    tbl.push_back('{40'd2,              40'd3,    40'd1,   2,   0,  0});
    tbl.push_back('{40'd2,              40'd3,    40'd1,   2,   1,  0});
    tbl.push_back('{40'd3,              40'd0,    40'd2,   0,   0,  0});
    tbl.push_back('{40'd2,              40'd4,    40'd0,   0,   1,  0});
    tbl.push_back('{40'd1,              40'd15,   40'd12,  0,   1,  0});
    tbl.push_back('{40'd4,              40'd0,    40'd0,   0,   0,  1});
    tbl.push_back('{40'd0,              40'd0,    40'd0,   0,   0,  1});
    tbl.push_back('{40'h1_0000_0001,    40'd0,    40'd0,   0,   0,  1});
    tbl.push_back('{40'd1,              40'd16,   40'd0,   0,   0,  1});
    tbl.push_back('{40'd1,              40'h1_0000_0000, 40'd0, 0, 0, 1});
    tbl.push_back('{40'd1,              40'd1,    40'd13,  0,   0,  1});

    for (int t = 0; t < tbl.size(); t++) begin
      do_reset();
      check($sformatf("v%0d.err_cleared", t), word_t'(err), '0);
      run_vec(tbl[t], $sformatf("v%0d", t), 1'b0);
    end

    // Minimal set with its documented payload.
    do_reset();
    w = {40'd1, 40'd0, 40'd0, 40'hAA};
    stream(w, 1'b0, 1'b0, cyc, early);
    check("min.cz_valid", word_t'(cz_valid), word_t'(1));
    check("min.c0",       czo_if.c[0],       40'hAA);
    check("min.latency",  word_t'(cyc),      word_t'(4));

    // Max set, element k = k: known landmark values.
    do_reset();
    v = '{40'd3, 40'd15, 40'd12, 1, 0, 0};
    run_vec(v, "max", 1'b0);
    check("max.g_2_14",  czo_if.g[2][14],  40'h32);
    check("max.a_11_14", czo_if.a[11][14], 40'hE6);
    check("max.b_11",    czo_if.b[11],     40'hF2);

    // Reload after ack; ack noise during the second load must be ignored.
    do_reset();
    v = '{40'd3, 40'd2, 40'd1, 0, 0, 0};
    run_vec(v, "reload1", 1'b1);
    @(negedge clk); cz_ack = 1'b1;
    @(negedge clk); cz_ack = 1'b0;
    check("ack.cz_valid", word_t'(cz_valid), '0);
    check("ack.s_ready",  word_t'(s_ready),  word_t'(1));
    check_set("ack.kept");
    v = '{40'd1, 40'd1, 40'd0, 0, 1, 0};
    run_vec(v, "reload2", 1'b1);
    check("reload2.c1", czo_if.c[1], '0);
    check("reload2.g01", czo_if.g[0][1], '0);

    // Reset in the middle of a max load discards the partial set.
    do_reset();
    v = '{40'd3, 40'd15, 40'd12, 1, 0, 0};
    build_words(v, w);
    w = w[0:9];
    stream(w, 1'b0, 1'b0, cyc, early);
    rst = 1'b1;
    @(posedge clk); #1;
    model_clear();
    check("midrst.s_ready",  word_t'(s_ready),  '0);
    check("midrst.cz_valid", word_t'(cz_valid), '0);
    check("midrst.err",      word_t'(err),      '0);
    check_set("midrst");
    @(negedge clk); rst = 1'b0;
    v = '{40'd1, 40'd0, 40'd0, 0, 0, 0};
    run_vec(v, "after_midrst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
